// File: rtl/alu_uart_ctrl.sv
// UART-side controller for an external combinational ALU: collects operand A, operand B and an
// opcode byte-by-byte (LSB first), captures the ALU result and streams it back out byte-by-byte.
module alu_uart_ctrl #(
  parameter int NB_DATA = 8,
  parameter int NB_OPS  = 6,
  parameter int NB_RES  = NB_DATA + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_done,
  input  logic [NB_RES-1:0] i_alu_res,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OPS-1:0]  o_ops,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int NBY_D = (NB_DATA + 7) / 8;
  localparam int NBY_R = (NB_RES + 7) / 8;
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    S_RX_A,
    S_RX_B,
    S_RX_OP,
    S_EXEC,
    S_TX_SEND,
    S_TX_WAIT
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [8*NBY_R-1:0]   res;
  logic                 last_d;
  logic                 last_r;

  assign last_d = (cnt == CNT_W'(NBY_D - 1));
  assign last_r = (cnt == CNT_W'(NBY_R - 1));
  assign o_busy = (state == S_EXEC) || (state == S_TX_SEND) || (state == S_TX_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_RX_A;
    else          state <= state_next;
  end

  // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_RX_A:    if (i_rx_done && last_d) state_next = S_RX_B;
      S_RX_B:    if (i_rx_done && last_d) state_next = S_RX_OP;
      S_RX_OP:   if (i_rx_done) state_next = S_EXEC;
      S_EXEC:    state_next = S_TX_SEND;
      S_TX_SEND: state_next = S_TX_WAIT;
      S_TX_WAIT: if (i_tx_done) state_next = last_r ? S_RX_A : S_TX_SEND;
      default:   state_next = S_RX_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      res        <= '0;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_ops      <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_valid    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_tx_start <= 1'b0;
      if (i_rx_done && o_busy) o_overrun <= 1'b1;
      case (state)
        S_RX_A: if (i_rx_done) begin
          // Only bits that exist in the field are written; excess bits of the top byte fall away.
          for (int i = 0; i < NB_DATA; i++)
            if (i / 8 == int'(cnt)) o_data_a[i] <= i_rx_data[i % 8];
          cnt <= last_d ? '0 : cnt + 1'b1;
        end
        S_RX_B: if (i_rx_done) begin
          for (int i = 0; i < NB_DATA; i++)
            if (i / 8 == int'(cnt)) o_data_b[i] <= i_rx_data[i % 8];
          cnt <= last_d ? '0 : cnt + 1'b1;
        end
        S_RX_OP: if (i_rx_done) o_ops <= i_rx_data[NB_OPS-1:0];
        S_EXEC: begin
          res     <= (8*NBY_R)'(i_alu_res);
          o_valid <= 1'b1;
        end
        S_TX_SEND: begin
          o_tx_start <= 1'b1;
          o_tx_data  <= res[8*cnt +: 8];
        end
        S_TX_WAIT: if (i_tx_done) cnt <= last_r ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: default 8-bit instance plus a 16-bit operand instance,
// checked with immediate assertions against hand-computed values.
module tb_alu_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data, rx_data16;
  logic        rx_done, rx_done16;
  logic        tx_done, tx_done16;
  logic [8:0]  alu_res;
  logic [16:0] alu_res16;

  logic [7:0]  data_a, data_b, tx_data;
  logic [5:0]  ops;
  logic        tx_start, valid, busy, overrun;

  logic [15:0] data_a16, data_b16;
  logic [5:0]  ops16;
  logic [7:0]  tx_data16;
  logic        tx_start16, valid16, busy16, overrun16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_uart_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_res(alu_res),
    .o_data_a(data_a), .o_data_b(data_b), .o_ops(ops), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_valid(valid), .o_busy(busy), .o_overrun(overrun)
  );

  alu_uart_ctrl #(.NB_DATA(16), .NB_OPS(6), .NB_RES(17)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data16), .i_rx_done(rx_done16),
    .i_tx_done(tx_done16), .i_alu_res(alu_res16),
    .o_data_a(data_a16), .o_data_b(data_b16), .o_ops(ops16), .o_tx_data(tx_data16),
    .o_tx_start(tx_start16), .o_valid(valid16), .o_busy(busy16), .o_overrun(overrun16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic send16(input logic [7:0] b);
    rx_data16 = b; rx_done16 = 1'b1;
    tick();
    rx_done16 = 1'b0;
  endtask

  // Called right after the opcode edge: checks o_valid timing, then both result bytes.
  task automatic run_tx8(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input bit inject);
    logic [7:0] exp_b [2];
    exp_b[0] = b0; exp_b[1] = b1;
    check({tag, "_valid_early"}, 32'(valid), 32'd0);
    check({tag, "_busy_exec"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check({tag, "_start"}, 32'(tx_start), 32'd1);
      check({tag, "_txbyte"}, 32'(tx_data), 32'(exp_b[k]));
      if (inject && k == 0) begin rx_data = 8'h99; rx_done = 1'b1; end
      tick();
      rx_done = 1'b0;
      check({tag, "_start_pulse"}, 32'(tx_start), 32'd0);
      check({tag, "_txhold"}, 32'(tx_data), 32'(exp_b[k]));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int starts;
    int busy_low;
    logic [7:0] exp16 [3];

    rst_n = 1'b0;
    rx_data = '0; rx_done = 1'b0; tx_done = 1'b0; alu_res = '0;
    rx_data16 = '0; rx_done16 = 1'b0; tx_done16 = 1'b0; alu_res16 = '0;
    tick(); tick();
    check("rst_a", 32'(data_a), 32'd0);
    check("rst_b", 32'(data_b), 32'd0);
    check("rst_ops", 32'(ops), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_ctrl", {28'd0, tx_start, valid, busy, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic transaction 5 op 3 with opcode 0x20.
    alu_res = 9'h008;
    send8(8'h05); send8(8'h03);
    check("t1_busy_rx", 32'(busy), 32'd0);
    send8(8'h20);
    check("t1_a", 32'(data_a), 32'h05);
    check("t1_b", 32'(data_b), 32'h03);
    check("t1_ops", 32'(ops), 32'h20);
    run_tx8("t1", 8'h08, 8'h00, 1'b0);

    // Opcode with discarded high bits; 9-bit result with MSB set.
    alu_res = 9'h1FF;
    send8(8'hAA); send8(8'h55); send8(8'hE3);
    check("t2_ops", 32'(ops), 32'h23);
    check("t2_a", 32'(data_a), 32'hAA);
    run_tx8("t2", 8'hFF, 8'h01, 1'b0);

    // Byte arriving during transmit is dropped and flags overrun.
    alu_res = 9'h1A5;
    send8(8'h0F); send8(8'h01); send8(8'h01);
    check("t3_ovr_before", 32'(overrun), 32'd0);
    run_tx8("t3", 8'hA5, 8'h01, 1'b1);
    check("t3_a_kept", 32'(data_a), 32'h0F);
    check("t3_b_kept", 32'(data_b), 32'h01);
    check("t3_ops_kept", 32'(ops), 32'h01);
    check("t3_overrun", 32'(overrun), 32'd1);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    check("t3_txdone_idle_start", 32'(tx_start), 32'd0);
    check("t3_txdone_idle_busy", 32'(busy), 32'd0);

    // Reset mid-reception, with an rx strobe coincident with reset.
    send8(8'h11); send8(8'h22);
    rst_n = 1'b0; rx_data = 8'h55; rx_done = 1'b1;
    tick();
    rst_n = 1'b1; rx_done = 1'b0;
    check("t4_rst_a", 32'(data_a), 32'd0);
    check("t4_rst_b", 32'(data_b), 32'd0);
    check("t4_rst_txdata", 32'(tx_data), 32'd0);
    check("t4_rst_ctrl", {28'd0, tx_start, valid, busy, overrun}, 32'd0);
    alu_res = 9'h009;
    send8(8'h07); send8(8'h02); send8(8'h22);
    check("t4_a", 32'(data_a), 32'h07);
    check("t4_b", 32'(data_b), 32'h02);
    check("t4_ops", 32'(ops), 32'h22);
    run_tx8("t4", 8'h09, 8'h00, 1'b0);

    // Transmitter stalls for 100 cycles.
    alu_res = 9'h13C;
    send8(8'h40); send8(8'h41); send8(8'h02);
    tick(); tick();
    check("t5_start", 32'(tx_start), 32'd1);
    check("t5_byte0", 32'(tx_data), 32'h3C);
    starts = 0; busy_low = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 50) begin rx_data = 8'h77; rx_done = 1'b1; end
      tick();
      rx_done = 1'b0;
      if (tx_start) starts++;
      if (!busy) busy_low++;
    end
    check("t5_extra_starts", 32'(starts), 32'd0);
    check("t5_busy_low_cycles", 32'(busy_low), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_a_kept", 32'(data_a), 32'h40);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    tick();
    check("t5_byte1", 32'(tx_data), 32'h01);
    tx_done = 1'b1; tick(); tx_done = 1'b0;
    check("t5_idle", 32'(busy), 32'd0);

    // Reset during transmission abandons the remaining bytes.
    alu_res = 9'h1FF;
    send8(8'h01); send8(8'h01); send8(8'h01);
    tick(); tick();
    check("t6_start", 32'(tx_start), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    starts = 0;
    for (int c = 0; c < 20; c++) begin
      tx_done = (c == 3);
      tick();
      if (tx_start) starts++;
    end
    tx_done = 1'b0;
    check("t6_no_starts", 32'(starts), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);

    // 16-bit operands, 17-bit result: three result bytes.
    alu_res16 = 17'h1ACAC;
    send16(8'h34); send16(8'h12); send16(8'h78); send16(8'h56); send16(8'h20);
    check("w_a", 32'(data_a16), 32'h1234);
    check("w_b", 32'(data_b16), 32'h5678);
    check("w_ops", 32'(ops16), 32'h20);
    check("w_valid_early", 32'(valid16), 32'd0);
    tick();
    check("w_valid", 32'(valid16), 32'd1);
    exp16[0] = 8'hAC; exp16[1] = 8'hAC; exp16[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("w_start", 32'(tx_start16), 32'd1);
      check("w_txbyte", 32'(tx_data16), 32'(exp16[k]));
      tick();
      check("w_start_pulse", 32'(tx_start16), 32'd0);
      tx_done16 = 1'b1; tick(); tx_done16 = 1'b0;
    end
    check("w_idle", 32'(busy16), 32'd0);
    tick();
    check("w_no_extra_start", 32'(tx_start16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
